pc_update_ras: RTL and testbench

//  Registered next-PC unit for the Y86-64 core; parametrised successor of the PC update stage.

---
 rtl/pc_update_ras.sv | 115 +++++++++++
 tb/tb_pc_update_ras.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_ras.sv
// Registered next-PC unit for the Y86-64 core with an optional return-address stack.
// Define PC_RAS_EN to build the stack; otherwise the RAS outputs are tied to zero.
module pc_update_ras #(
  parameter int             W         = 64,
  parameter int             RAS_DEPTH = 8,
  parameter logic [W-1:0]   RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic [3:0]                     icode,
  input  logic                           cnd,
  input  logic [W-1:0]                   valC,
  input  logic [W-1:0]                   valP,
  input  logic [W-1:0]                   valM,
  output logic [W-1:0]                   pc,
  output logic                           halted,
  output logic                           invalid,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_mispredict,
  output logic                           ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [3:0] I_HALT = 4'd0;
  localparam logic [3:0] I_JXX  = 4'd7;
  localparam logic [3:0] I_CALL = 4'd8;
  localparam logic [3:0] I_RET  = 4'd9;

  logic         upd;
  logic         is_call;
  logic         is_ret;
  logic         set_halt;
  logic         set_inv;
  logic [W-1:0] next_pc;

  always_comb begin
    upd      = !stall && !halted && !invalid;
    is_call  = upd && (icode == I_CALL);
    is_ret   = upd && (icode == I_RET);
    set_halt = upd && (icode == I_HALT);
    set_inv  = upd && (icode > 4'd11);
    next_pc  = valP;
    case (icode)
      I_JXX:  next_pc = cnd ? valC : valP;
      I_CALL: next_pc = valC;
      I_RET:  next_pc = valM;
      4'd0, 4'd12, 4'd13, 4'd14, 4'd15: next_pc = pc;
      default: next_pc = valP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      halted  <= 1'b0;
      invalid <= 1'b0;
    end else if (upd) begin
      pc <= next_pc;
      if (set_halt) halted  <= 1'b1;
      if (set_inv)  invalid <= 1'b1;
    end
  end

`ifdef PC_RAS_EN
  localparam int          PW   = $clog2(RAS_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [W-1:0]  stack [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_dec;
  logic [W-1:0]  top;

  // ptr addresses the next free slot; the newest entry sits one below it.
  always_comb begin
    ptr_dec = ptr - 1'b1;
    top     = stack[ptr_dec];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr            <= '0;
      ras_count      <= '0;
      ras_mispredict <= 1'b0;
      ras_underflow  <= 1'b0;
    end else begin
      ras_mispredict <= 1'b0;
      ras_underflow  <= 1'b0;
      if (is_call) begin
        ptr <= ptr + 1'b1;
        if (ras_count != FULL) ras_count <= ras_count + 1'b1;
      end else if (is_ret) begin
        if (ras_count == '0) begin
          ras_underflow <= 1'b1;
        end else begin
          ptr            <= ptr_dec;
          ras_count      <= ras_count - 1'b1;
          ras_mispredict <= (top != valM);
        end
      end
    end
  end

  // Stack contents are pure data and need no reset; a full push overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (is_call) stack[ptr] <= valP;
  end
`else
  assign ras_count      = '0;
  assign ras_mispredict = 1'b0;
  assign ras_underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_update_ras.sv
// Randomized bench for pc_update_ras against a queue-based behavioural model.
module tb_pc_update_ras;

  localparam int          W     = 64;
  localparam int          DEPTH = 8;
  localparam logic [63:0] RPC   = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [3:0]  icode;
  logic        cnd;
  logic [63:0] valC, valP, valM;
  logic [63:0] pc;
  logic        halted, invalid;
  logic [3:0]  ras_count;
  logic        ras_mispredict, ras_underflow;

  pc_update_ras #(.W(W), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .icode(icode), .cnd(cnd),
    .valC(valC), .valP(valP), .valM(valM), .pc(pc), .halted(halted),
    .invalid(invalid), .ras_count(ras_count), .ras_mispredict(ras_mispredict),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [63:0] m_pc;
  logic        m_halt, m_inv, m_mis, m_und;
  logic [63:0] m_stack[$];
  bit          chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_count();
`ifdef PC_RAS_EN
    return m_stack.size();
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_halt = 0; m_inv = 0; m_mis = 0; m_und = 0;
    m_stack.delete();
  endtask

  task automatic model_step(input logic [3:0] ic, input logic c,
                            input logic [63:0] vc, vp, vm, input logic st);
    logic [63:0] v;
    m_mis = 0; m_und = 0;
    if (st || m_halt || m_inv) return;
    if (ic == 0)       m_halt = 1;
    else if (ic >= 12) m_inv = 1;
    else if (ic == 7)  m_pc = c ? vc : vp;
    else if (ic == 8) begin
      m_pc = vc;
      m_stack.push_back(vp);
      if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
    end else if (ic == 9) begin
      m_pc = vm;
      if (m_stack.size() == 0) m_und = 1;
      else begin
        v = m_stack.pop_back();
        m_mis = (v != vm);
      end
    end else m_pc = vp;
`ifndef PC_RAS_EN
    m_mis = 0; m_und = 0;
`endif
  endtask

  // Every cycle outside reset the registered outputs must equal the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("pc", pc, m_pc);
      chk("halted", 64'(halted), 64'(m_halt));
      chk("invalid", 64'(invalid), 64'(m_inv));
      chk("ras_count", 64'(ras_count), 64'(exp_count()));
      chk("ras_mispredict", 64'(ras_mispredict), 64'(m_mis));
      chk("ras_underflow", 64'(ras_underflow), 64'(m_und));
    end
  end

  task automatic step(input logic [3:0] ic, input logic c,
                      input logic [63:0] vc, vp, vm, input logic st);
    icode = ic; cnd = c; valC = vc; valP = vp; valM = vm; stall = st;
    @(posedge clk);
    model_step(ic, c, vc, vp, vm, st);
    @(negedge clk);
  endtask

  task automatic rand_step(input bit allow_stop);
    logic [3:0]  ic;
    logic [63:0] vm;
    ic = 4'($urandom_range(1, 11));
    if (allow_stop && ($urandom % 8 == 0)) ic = 4'($urandom_range(12, 15));
    if (ic == 4 && $urandom % 3 == 0) ic = 4'd8;
    if (ic == 5 && $urandom % 3 == 0) ic = 4'd9;
    vm = {$urandom, $urandom};
    if (m_stack.size() > 0 && ($urandom % 2 == 1)) vm = m_stack[$];
    step(ic, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, vm,
         ($urandom % 5 == 0));
  endtask

  // Asserts reset in the middle of a cycle and checks the outputs before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_pc", pc, RPC);
    chk("async_count", 64'(ras_count), 64'd0);
    chk("async_halted", 64'(halted), 64'd0);
    chk("async_invalid", 64'(invalid), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [63:0] frozen;

  initial begin
    rst_n = 0; stall = 0; icode = 4'd1; cnd = 0; valC = 0; valP = 0; valM = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_pc", pc, RPC);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_count", 64'(ras_count), 64'd0);
    rst_n = 1;
    chk_en = 1;

    step(4'd7, 1, 64'h40, 64'h2A, 64'h0, 0);
    chk("jxx_taken", pc, 64'h40);
    step(4'd7, 0, 64'h40, 64'h2A, 64'h0, 0);
    chk("jxx_not_taken", pc, 64'h2A);

    step(4'd8, 0, 64'h200, 64'h109, 64'h0, 0);
    chk("call_pc", pc, 64'h200);
`ifdef PC_RAS_EN
    chk("call_count", 64'(ras_count), 64'd1);
`endif
    step(4'd9, 0, 64'h0, 64'h0, 64'h109, 0);
    chk("ret_pc", pc, 64'h109);
    chk("ret_mis", 64'(ras_mispredict), 64'd0);
    step(4'd8, 0, 64'h200, 64'h109, 64'h0, 0);
    step(4'd9, 0, 64'h0, 64'h0, 64'h500, 0);
    chk("ret_bad_pc", pc, 64'h500);
`ifdef PC_RAS_EN
    chk("ret_bad_mis", 64'(ras_mispredict), 64'd1);
`endif
    step(4'd1, 0, 64'h0, 64'h600, 64'h0, 0);
    chk("mis_pulse_clear", 64'(ras_mispredict), 64'd0);

    for (int i = 1; i <= 9; i++) step(4'd8, 0, 64'h3000 + 64'(i), 64'h1000 + 64'(i), 64'h0, 0);
`ifdef PC_RAS_EN
    chk("full_count", 64'(ras_count), 64'd8);
`endif
    for (int i = 9; i >= 2; i--) step(4'd9, 0, 64'h0, 64'h0, 64'h1000 + 64'(i), 0);
    chk("lifo_no_mis", 64'(ras_mispredict), 64'd0);
    step(4'd9, 0, 64'h0, 64'h0, 64'h777, 0);
    chk("under_pc", pc, 64'h777);
`ifdef PC_RAS_EN
    chk("underflow", 64'(ras_underflow), 64'd1);
`endif
    chk("under_count", 64'(ras_count), 64'd0);

    step(4'd8, 0, 64'h900, 64'h901, 64'h0, 0);
    frozen = pc;
    step(4'd8, 0, 64'hA00, 64'hA01, 64'h0, 1);
    chk("stall_pc", pc, frozen);
`ifdef PC_RAS_EN
    chk("stall_count", 64'(ras_count), 64'd1);
`endif
    step(4'd0, 0, 64'h0, 64'h0, 64'h0, 1);
    chk("stall_halt", 64'(halted), 64'd0);

    repeat (300) rand_step(0);

    step(4'd0, 0, 64'h0, 64'h0, 64'h0, 0);
    chk("halt_set", 64'(halted), 64'd1);
    frozen = pc;
    repeat (20) rand_step(0);
    chk("halt_frozen", pc, frozen);
    async_reset();

    step(4'd13, 0, 64'h0, 64'h0, 64'h0, 0);
    chk("inv_set", 64'(invalid), 64'd1);
    chk("inv_pc", pc, RPC);
    repeat (20) rand_step(0);
    chk("inv_frozen", pc, RPC);
    async_reset();

    for (int k = 0; k < 8; k++) begin
      repeat (150) rand_step(1);
      async_reset();
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
